// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned GNT_W   = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_GRANT0  = 2'd1;
    localparam logic [STATE_W-1:0] ST_GRANT1  = 2'd2;
    localparam logic [STATE_W-1:0] ST_TIMEOUT = 2'd3;

    localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
    localparam logic [GNT_W-1:0] GNT_M0   = 2'b01;
    localparam logic [GNT_W-1:0] GNT_M1   = 2'b10;

    // One-hot owner encoding for a given arbiter state.
    function automatic logic [GNT_W-1:0] gnt_of(input logic [STATE_W-1:0] st);
        logic [GNT_W-1:0] g;
        g = GNT_NONE;
        if (st == ST_GRANT0) g = GNT_M0;
        if (st == ST_GRANT1) g = GNT_M1;
        return g;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating bus-watchdog counter; hit_c_o flags the cycle the count reaches THRESH.
module wb_timeout_cnt #(
    parameter int unsigned THRESH    = 255,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_c_o
);

    localparam logic [CNT_WIDTH-1:0] HIT_AT = CNT_WIDTH'((THRESH > 0) ? THRESH - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] SAT_AT = CNT_WIDTH'(THRESH);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT_AT)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Threshold reached by this cycle's increment; never fires when THRESH is 0.
    assign hit_c_o = (THRESH != 0) && en_i && (cnt_q == HIT_AT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter: round-robin, cycle-held grant, watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic               last_owner_q, last_owner_d;   // 0 = m0, 1 = m1; also the TIMEOUT owner
    logic               pulse_q, pulse_d;

    logic req0, req1, gnt0, gnt1;
    logic cnt_clr, cnt_en, cnt_hit;
    logic err_only;

    assign req0     = m0_cyc_i & m0_stb_i;
    assign req1     = m1_cyc_i & m1_stb_i;
    assign gnt0     = (state_q == ST_GRANT0);
    assign gnt1     = (state_q == ST_GRANT1);
    assign err_only = s_err_i & ~s_ack_i;

    // Next-state: round-robin pick in IDLE, release/handover or watchdog in GRANTx.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        pulse_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && (!req1 || last_owner_q)) state_d = ST_GRANT0;
                else if (req1)                      state_d = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (!m0_cyc_i) begin
                    last_owner_d = 1'b0;
                    state_d      = req1 ? ST_GRANT1 : ST_IDLE;
                end else if (cnt_hit) begin
                    last_owner_d = 1'b0;
                    pulse_d      = 1'b1;
                    state_d      = ST_TIMEOUT;
                end
            end
            ST_GRANT1: begin
                if (!m1_cyc_i) begin
                    last_owner_d = 1'b1;
                    state_d      = req0 ? ST_GRANT0 : ST_IDLE;
                end else if (cnt_hit) begin
                    last_owner_d = 1'b1;
                    pulse_d      = 1'b1;
                    state_d      = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: begin
                if (!(last_owner_q ? m1_cyc_i : m0_cyc_i)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and timeout pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            pulse_q      <= pulse_d;
        end
    end

    // Slave side is a grant-qualified copy of the owner; forced idle otherwise.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (gnt0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_cyc_i & m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
        end else if (gnt1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_cyc_i & m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
        end
    end

    // Responses go to the owner only; ack beats err, late responses are dropped.
    always_comb begin
        m0_ack_o  = gnt0 & m0_cyc_i & s_ack_i;
        m1_ack_o  = gnt1 & m1_cyc_i & s_ack_i;
        m0_err_o  = (gnt0 & m0_cyc_i & err_only) | (pulse_q & ~last_owner_q);
        m1_err_o  = (gnt1 & m1_cyc_i & err_only) | (pulse_q & last_owner_q);
        m0_data_o = gnt0 ? s_data_i : '0;
        m1_data_o = gnt1 ? s_data_i : '0;
        grant_o   = gnt_of(state_q);
        timeout_o = pulse_q;
    end

    assign cnt_en  = (gnt0 | gnt1) & s_stb_o & ~s_ack_i & ~s_err_i;
    assign cnt_clr = ~(gnt0 | gnt1) | (state_d != state_q) | s_ack_i | s_err_i;

    wb_timeout_cnt #(
        .THRESH    (TIMEOUT_CYCLES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .hit_c_o (cnt_hit)
    );

endmodule
